rs_gen: RTL and testbench

RS_GEN -- requirements
Module: rs_gen

---
 rtl/rs_gen_pkg.sv | 91 +++++++++
 rtl/rs_age_select.sv | 65 ++++++
 rtl/rs_gen.sv | 203 ++++++++++++++++++++
 tb/tb_rs_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_gen_pkg
// Purpose  : Shared types, FU bit map and opcode-to-FU-class helper for the
//            reservation station.
// Revision : 1.0 - initial release
// ============================================================================
package rs_gen_pkg;

  localparam int C_PREG_NUM = 64;
  localparam int C_TAG_W    = $clog2(C_PREG_NUM);

  // Functional-unit bit map: two ALUs, branch unit, load/store unit, multiplier
  localparam int C_FU_NUM  = 5;
  localparam int C_FU_ALU0 = 0;
  localparam int C_FU_ALU1 = 1;
  localparam int C_FU_BR   = 2;
  localparam int C_FU_LSU  = 3;
  localparam int C_FU_MULT = 4;

  // RISC-V major opcodes that select a non-ALU unit
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    FULL      = 2'd0,
    ONE_LEFT  = 2'd1,
    MORE_LEFT = 2'd2
  } STRUCTURE_FULL;

  // Decoded fields that do not name a register
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc;
  } DECODE_NOREG_PACKET;

  typedef struct packed {
    logic [C_TAG_W-1:0] dest_tag;
    logic [C_TAG_W-1:0] src1_tag;
    logic [C_TAG_W-1:0] src2_tag;
    logic               src1_ready;
    logic               src2_ready;
    DECODE_NOREG_PACKET decode;
  } RS_DISP_PACKET;

  typedef struct packed {
    logic          valid;
    RS_DISP_PACKET pkt;
  } RS_ENTRY;

  typedef struct packed {
    logic [C_TAG_W-1:0] dest_tag;
    logic [C_TAG_W-1:0] src1_tag;
    logic [C_TAG_W-1:0] src2_tag;
    DECODE_NOREG_PACKET decode;
  } RS_FU_PACKET;

  // Set of FUs able to execute an op; ALU ops may use either ALU
  function automatic logic [C_FU_NUM-1:0] fu_class_mask(input logic [6:0] opcode,
                                                        input logic [6:0] funct7);
    logic [C_FU_NUM-1:0] m;
    m = '0;
    case (opcode)
      C_OP_LOAD, C_OP_STORE:           m[C_FU_LSU] = 1'b1;
      C_OP_BRANCH, C_OP_JAL, C_OP_JALR: m[C_FU_BR]  = 1'b1;
      C_OP_OP: begin
        if (funct7 == C_F7_MULDIV) begin
          m[C_FU_MULT] = 1'b1;
        end else begin
          m[C_FU_ALU0] = 1'b1;
          m[C_FU_ALU1] = 1'b1;
        end
      end
      default: begin
        m[C_FU_ALU0] = 1'b1;
        m[C_FU_ALU1] = 1'b1;
      end
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select
// Purpose  : Oldest-first issue select. Each port takes the oldest remaining
//            eligible entry that still has a free, ready FU of its class.
// Revision : 1.0 - initial release
// ============================================================================
module rs_age_select
  import rs_gen_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int ISSUE_W  = 2,
  parameter int FU_NUM   = 5
) (
  input  logic [RS_DEPTH-1:0]               i_elig,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] i_age,      // [r][c]=1: r older than c
  input  logic [RS_DEPTH-1:0][FU_NUM-1:0]   i_fu_mask,
  input  logic [FU_NUM-1:0]                 i_fu_ready,
  output logic [ISSUE_W-1:0][RS_DEPTH-1:0]  o_grant,
  output logic [ISSUE_W-1:0][FU_NUM-1:0]    o_fu_sel,
  output logic [ISSUE_W-1:0]                o_valid
);

  // Sequential port-by-port pick; each pick removes its entry and its FU
  always_comb begin
    logic [RS_DEPTH-1:0] w_remain;
    logic [RS_DEPTH-1:0] w_cand;
    logic [FU_NUM-1:0]   w_avail;
    logic [FU_NUM-1:0]   w_hit;
    logic                w_found;
    logic                w_older;
    w_remain = i_elig;
    w_avail  = i_fu_ready;
    w_cand   = '0;
    w_hit    = '0;
    w_found  = 1'b0;
    w_older  = 1'b0;
    o_grant  = '0;
    o_fu_sel = '0;
    o_valid  = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_cand[i] = w_remain[i] && (|(i_fu_mask[i] & w_avail));
      end
      w_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_older = 1'b0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (w_cand[j] && i_age[j][i]) w_older = 1'b1;
        end
        if (w_cand[i] && !w_older && !w_found) begin
          w_found       = 1'b1;
          o_grant[p][i] = 1'b1;
          o_valid[p]    = 1'b1;
          w_hit         = i_fu_mask[i] & w_avail;
          o_fu_sel[p]   = w_hit & (~w_hit + FU_NUM'(1));  // lowest ready unit
        end
      end
      w_remain = w_remain & ~o_grant[p];
      w_avail  = w_avail & ~o_fu_sel[p];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_gen.sv
`default_nettype none
// ============================================================================
// Module   : rs_gen
// Purpose  : Generic reservation station: multi-lane dispatch, CDB wakeup with
//            dispatch bypass, age-matrix oldest-first multi-port issue.
// Revision : 1.0 - initial release
// ============================================================================
module rs_gen
  import rs_gen_pkg::*;
#(
  parameter int RS_DEPTH   = 8,
  parameter int DISPATCH_W = 2,
  parameter int CDB_W      = 2,
  parameter int ISSUE_W    = 2,
  parameter int FU_NUM     = C_FU_NUM,
  parameter int PREG_NUM   = C_PREG_NUM
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [DISPATCH_W-1:0]                 dispatch_en_i,
  input  RS_DISP_PACKET [DISPATCH_W-1:0]        dispatch_pkt_i,
  input  logic [CDB_W-1:0]                      cdb_en_i,
  input  logic [CDB_W-1:0][$clog2(PREG_NUM)-1:0] cdb_tag_i,
  input  logic                                  flush_i,
  input  logic [FU_NUM-1:0]                     fu_ready_i,
  output logic [ISSUE_W-1:0]                    issue_valid_o,
  output RS_FU_PACKET [ISSUE_W-1:0]             issue_pkt_o,
  output logic [ISSUE_W-1:0][FU_NUM-1:0]        issue_fu_sel_o,
  output logic [$clog2(RS_DEPTH):0]             free_cnt_o,
  output STRUCTURE_FULL                         rs_full_o
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  RS_ENTRY [RS_DEPTH-1:0]               r_entry;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]    r_age;
  logic [CNT_W-1:0]                     r_free_cnt;
  logic [ISSUE_W-1:0]                   r_issue_valid;
  RS_FU_PACKET [ISSUE_W-1:0]            r_issue_pkt;
  logic [ISSUE_W-1:0][FU_NUM-1:0]       r_issue_sel;

  RS_ENTRY [RS_DEPTH-1:0]               w_entry_n;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]    w_age_n;
  logic [CNT_W-1:0]                     w_free_n;
  logic [RS_DEPTH-1:0]                  w_alloc;
  logic [RS_DEPTH-1:0][DISPATCH_W-1:0]  w_lane_oh;
  logic [RS_DEPTH-1:0]                  w_elig;
  logic [RS_DEPTH-1:0][FU_NUM-1:0]      w_fu_mask;
  logic [ISSUE_W-1:0][RS_DEPTH-1:0]     w_grant;
  logic [ISSUE_W-1:0][FU_NUM-1:0]       w_gsel;
  logic [ISSUE_W-1:0]                   w_gvalid;
  logic [RS_DEPTH-1:0]                  w_issued;
  RS_FU_PACKET [ISSUE_W-1:0]            w_issue_pkt;

  // Eligibility uses ready bits as registered at cycle start
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_elig[i]    = r_entry[i].valid && r_entry[i].pkt.src1_ready && r_entry[i].pkt.src2_ready;
      w_fu_mask[i] = fu_class_mask(r_entry[i].pkt.decode.opcode, r_entry[i].pkt.decode.funct7);
    end
  end

  rs_age_select #(
    .RS_DEPTH (RS_DEPTH),
    .ISSUE_W  (ISSUE_W),
    .FU_NUM   (FU_NUM)
  ) u_age_select (
    .i_elig     (w_elig),
    .i_age      (r_age),
    .i_fu_mask  (w_fu_mask),
    .i_fu_ready (fu_ready_i),
    .o_grant    (w_grant),
    .o_fu_sel   (w_gsel),
    .o_valid    (w_gvalid)
  );

  // Collapse grants per entry and mux the granted entry onto each port
  always_comb begin
    w_issued    = '0;
    w_issue_pkt = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      w_issued = w_issued | w_grant[p];
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_grant[p][i]) begin
          w_issue_pkt[p].dest_tag = r_entry[i].pkt.dest_tag;
          w_issue_pkt[p].src1_tag = r_entry[i].pkt.src1_tag;
          w_issue_pkt[p].src2_tag = r_entry[i].pkt.src2_tag;
          w_issue_pkt[p].decode   = r_entry[i].pkt.decode;
        end
      end
    end
  end

  // Lane k lands in the k-th lowest slot that was invalid at cycle start,
  // so slots just freed by issue are never reused in the same cycle
  always_comb begin
    int n;
    n         = 0;
    w_alloc   = '0;
    w_lane_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!r_entry[i].valid && n < DISPATCH_W) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (k == n && dispatch_en_i[k]) begin
            w_alloc[i]      = 1'b1;
            w_lane_oh[i][k] = 1'b1;
          end
        end
        n = n + 1;
      end
    end
  end

  // Next entry state: wakeup, issue clear, dispatch write (with CDB bypass), age update
  always_comb begin
    w_entry_n = r_entry;
    w_age_n   = r_age;
    if (flush_i) begin
      w_entry_n = '0;
      w_age_n   = '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_alloc[i]) begin
          for (int k = 0; k < DISPATCH_W; k++) begin
            if (w_lane_oh[i][k]) w_entry_n[i].pkt = dispatch_pkt_i[k];
          end
          w_entry_n[i].valid = 1'b1;
        end else if (w_issued[i]) begin
          w_entry_n[i].valid = 1'b0;
        end
        for (int c = 0; c < CDB_W; c++) begin
          if (cdb_en_i[c] && cdb_tag_i[c] == w_entry_n[i].pkt.src1_tag) w_entry_n[i].pkt.src1_ready = 1'b1;
          if (cdb_en_i[c] && cdb_tag_i[c] == w_entry_n[i].pkt.src2_tag) w_entry_n[i].pkt.src2_ready = 1'b1;
        end
      end
      // New entries are younger than everything resident; among same-cycle
      // dispatches the lower slot holds the lower lane and is older
      for (int r = 0; r < RS_DEPTH; r++) begin
        for (int c = 0; c < RS_DEPTH; c++) begin
          if (r == c) begin
            w_age_n[r][c] = 1'b0;
          end else if (w_alloc[c]) begin
            w_age_n[r][c] = w_alloc[r] ? (r < c) : 1'b1;
          end else if (w_alloc[r]) begin
            w_age_n[r][c] = 1'b0;
          end
        end
      end
    end
  end

  // Free count reflecting post-edge contents
  always_comb begin
    w_free_n = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_free_n = w_free_n + CNT_W'(!w_entry_n[i].valid);
    end
  end

  // Entry, age and occupancy state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_entry    <= '0;
      r_age      <= '0;
      r_free_cnt <= CNT_W'(RS_DEPTH);
    end else begin
      r_entry    <= w_entry_n;
      r_age      <= w_age_n;
      r_free_cnt <= w_free_n;
    end
  end

  // Registered issue ports; a flush suppresses this cycle's selection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_valid <= '0;
      r_issue_pkt   <= '0;
      r_issue_sel   <= '0;
    end else if (flush_i) begin
      r_issue_valid <= '0;
      r_issue_pkt   <= '0;
      r_issue_sel   <= '0;
    end else begin
      r_issue_valid <= w_gvalid;
      r_issue_pkt   <= w_issue_pkt;
      r_issue_sel   <= w_gsel;
    end
  end

  // Occupancy class decoded from the registered free count
  always_comb begin
    rs_full_o = MORE_LEFT;
    if (r_free_cnt == '0)             rs_full_o = FULL;
    else if (r_free_cnt == CNT_W'(1)) rs_full_o = ONE_LEFT;
  end

  assign issue_valid_o  = r_issue_valid;
  assign issue_pkt_o    = r_issue_pkt;
  assign issue_fu_sel_o = r_issue_sel;
  assign free_cnt_o     = r_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rs_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_gen
// Purpose  : Directed self-checking bench for rs_gen with an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_gen;
  import rs_gen_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [1:0]                 dispatch_en_i;
  RS_DISP_PACKET [1:0]        dispatch_pkt_i;
  logic [1:0]                 cdb_en_i;
  logic [1:0][C_TAG_W-1:0]    cdb_tag_i;
  logic                       flush_i;
  logic [4:0]                 fu_ready_i;
  logic [1:0]                 issue_valid_o;
  RS_FU_PACKET [1:0]          issue_pkt_o;
  logic [1:0][4:0]            issue_fu_sel_o;
  logic [3:0]                 free_cnt_o;
  STRUCTURE_FULL              rs_full_o;

  typedef struct packed {
    logic [5:0] dest;
    logic [4:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  rs_gen dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dispatch_en_i  (dispatch_en_i),
    .dispatch_pkt_i (dispatch_pkt_i),
    .cdb_en_i       (cdb_en_i),
    .cdb_tag_i      (cdb_tag_i),
    .flush_i        (flush_i),
    .fu_ready_i     (fu_ready_i),
    .issue_valid_o  (issue_valid_o),
    .issue_pkt_o    (issue_pkt_o),
    .issue_fu_sel_o (issue_fu_sel_o),
    .free_cnt_o     (free_cnt_o),
    .rs_full_o      (rs_full_o)
  );

  always #5 clk = ~clk;

  function automatic RS_DISP_PACKET mk(input int dest, input int s1, input logic r1,
                                       input int s2, input logic r2, input logic [6:0] op);
    RS_DISP_PACKET p;
    p               = '0;
    p.dest_tag      = 6'(dest);
    p.src1_tag      = 6'(s1);
    p.src2_tag      = 6'(s2);
    p.src1_ready    = r1;
    p.src2_ready    = r2;
    p.decode.opcode = op;
    p.decode.imm    = 32'(dest);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int dest, input logic [4:0] sel);
    exp_t e;
    e.dest = 6'(dest);
    e.sel  = sel;
    sb.push_back(e);
  endtask

  // Advance one edge, then score every issue port against the queue
  task automatic tick();
    exp_t e;
    logic [$bits(RS_FU_PACKET)-1:0] v;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (issue_valid_o[p]) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("issue_dest", 32'(issue_pkt_o[p].dest_tag), 32'(e.dest));
          chk("issue_sel", 32'(issue_fu_sel_o[p]), 32'(e.sel));
        end
      end else begin
        v = issue_pkt_o[p];
        chk("idle_pkt", 32'(|v), 32'd0);
        chk("idle_sel", 32'(issue_fu_sel_o[p]), 32'd0);
      end
    end
  endtask

  task automatic idle_inputs();
    dispatch_en_i  = '0;
    dispatch_pkt_i = '0;
    cdb_en_i       = '0;
    cdb_tag_i      = '0;
    flush_i        = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    fu_ready_i = '0;
    idle_inputs();
    #12;
    chk("rst_free", 32'(free_cnt_o), 32'd8);
    chk("rst_full", 32'(rs_full_o), 32'(MORE_LEFT));
    chk("rst_valid", 32'(issue_valid_o), 32'd0);
    reset_n = 1'b1;

    // ---- Fill: four cycles of two ready ALU ops, no FU ready
    for (int c = 0; c < 4; c++) begin
      dispatch_en_i     = 2'b11;
      dispatch_pkt_i[0] = mk(2*c+1, 0, 1, 0, 1, OP_ALU);
      dispatch_pkt_i[1] = mk(2*c+2, 0, 1, 0, 1, OP_ALU);
      tick();
      chk("fill_free", 32'(free_cnt_o), 32'(6 - 2*c));
    end
    chk("fill_full", 32'(rs_full_o), 32'(FULL));
    dispatch_pkt_i[0] = mk(9, 0, 1, 0, 1, OP_ALU);
    dispatch_pkt_i[1] = mk(10, 0, 1, 0, 1, OP_ALU);
    tick();
    chk("drop_free", 32'(free_cnt_o), 32'd0);
    idle_inputs();
    fu_ready_i = 5'b00011;
    for (int c = 0; c < 4; c++) begin
      push(2*c+1, 5'b00001);
      push(2*c+2, 5'b00010);
      tick();
      chk("drain_valid", 32'(issue_valid_o), 32'd3);
      chk("drain_free", 32'(free_cnt_o), 32'(2 + 2*c));
    end
    tick();
    chk("drain_idle", 32'(issue_valid_o), 32'd0);

    // ---- Age: A waits on tag 5, younger B/C issue first
    dispatch_en_i     = 2'b01;
    dispatch_pkt_i[0] = mk(20, 5, 0, 0, 1, OP_ALU);
    tick();
    chk("age_free_a", 32'(free_cnt_o), 32'd7);
    dispatch_en_i     = 2'b11;
    dispatch_pkt_i[0] = mk(21, 0, 1, 0, 1, OP_ALU);
    dispatch_pkt_i[1] = mk(22, 0, 1, 0, 1, OP_ALU);
    push(21, 5'b00001);
    push(22, 5'b00010);
    push(20, 5'b00001);
    tick();
    chk("age_wait", 32'(issue_valid_o), 32'd0);
    idle_inputs();
    cdb_en_i     = 2'b01;
    cdb_tag_i[0] = 6'd5;
    tick();
    chk("age_bc", 32'(issue_valid_o), 32'd3);
    cdb_en_i = '0;
    tick();
    chk("age_a", 32'(issue_valid_o), 32'd1);
    chk("age_free", 32'(free_cnt_o), 32'd8);

    // ---- Bypass: CDB tag 9 on port 1 during dispatch
    dispatch_en_i     = 2'b01;
    dispatch_pkt_i[0] = mk(30, 9, 0, 9, 0, OP_ALU);
    cdb_en_i          = 2'b10;
    cdb_tag_i[0]      = 6'd3;
    cdb_tag_i[1]      = 6'd9;
    push(30, 5'b00001);
    tick();
    chk("byp_hold", 32'(issue_valid_o), 32'd0);
    idle_inputs();
    tick();
    chk("byp_issue", 32'(issue_valid_o), 32'd1);

    // ---- FU conflict: two loads, only the LSU ready
    fu_ready_i        = 5'b01000;
    dispatch_en_i     = 2'b11;
    dispatch_pkt_i[0] = mk(40, 0, 1, 0, 1, OP_LOAD);
    dispatch_pkt_i[1] = mk(41, 0, 1, 0, 1, OP_LOAD);
    push(40, 5'b01000);
    push(41, 5'b01000);
    tick();
    idle_inputs();
    tick();
    chk("lsu_first", 32'(issue_valid_o), 32'd1);
    tick();
    chk("lsu_second", 32'(issue_valid_o), 32'd1);
    tick();
    chk("lsu_idle", 32'(issue_valid_o), 32'd0);

    // ---- One-left then flush
    fu_ready_i = '0;
    for (int c = 0; c < 4; c++) begin
      dispatch_en_i     = (c == 3) ? 2'b01 : 2'b11;
      dispatch_pkt_i[0] = mk(42 + 2*c, 0, 1, 0, 1, OP_ALU);
      dispatch_pkt_i[1] = mk(43 + 2*c, 0, 1, 0, 1, OP_ALU);
      tick();
    end
    chk("one_left_cnt", 32'(free_cnt_o), 32'd1);
    chk("one_left", 32'(rs_full_o), 32'(ONE_LEFT));
    idle_inputs();
    flush_i = 1'b1;
    tick();
    chk("flush1_free", 32'(free_cnt_o), 32'd8);

    // ---- Flush with six resident entries and two dispatching
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      dispatch_en_i     = 2'b11;
      dispatch_pkt_i[0] = mk(1 + 2*c, 0, 1, 0, 1, OP_ALU);
      dispatch_pkt_i[1] = mk(2 + 2*c, 0, 1, 0, 1, OP_ALU);
      tick();
    end
    chk("pre_flush_free", 32'(free_cnt_o), 32'd2);
    chk("pre_flush_full", 32'(rs_full_o), 32'(MORE_LEFT));
    fu_ready_i = 5'b11111;
    flush_i    = 1'b1;
    tick();
    chk("flush_free", 32'(free_cnt_o), 32'd8);
    chk("flush_valid", 32'(issue_valid_o), 32'd0);
    idle_inputs();
    tick();
    chk("post_flush_valid", 32'(issue_valid_o), 32'd0);

    // ---- Asynchronous reset while issue ports are busy
    fu_ready_i        = 5'b00011;
    dispatch_en_i     = 2'b11;
    dispatch_pkt_i[0] = mk(50, 0, 1, 0, 1, OP_ALU);
    dispatch_pkt_i[1] = mk(51, 0, 1, 0, 1, OP_ALU);
    tick();
    dispatch_pkt_i[0] = mk(52, 0, 1, 0, 1, OP_ALU);
    dispatch_pkt_i[1] = mk(53, 0, 1, 0, 1, OP_ALU);
    push(50, 5'b00001);
    push(51, 5'b00010);
    tick();
    chk("mid_valid", 32'(issue_valid_o), 32'd3);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(issue_valid_o), 32'd0);
    chk("arst_pkt0", 32'(issue_pkt_o[0].dest_tag), 32'd0);
    chk("arst_sel", 32'(issue_fu_sel_o), 32'd0);
    chk("arst_free", 32'(free_cnt_o), 32'd8);
    chk("arst_full", 32'(rs_full_o), 32'(MORE_LEFT));
    #1;
    reset_n = 1'b1;
    tick();
    chk("arst_drop", 32'(issue_valid_o), 32'd0);
    tick();
    chk("arst_drop2", 32'(issue_valid_o), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
